// File: rtl/alu_port_arbiter.sv
// Round-robin arbiter sharing the frame memory processing port
// between two requesters, with bounded bursts and tagged read return.
module alu_port_arbiter #(
    parameter int unsigned RADDR_W = 13,
    parameter int unsigned WADDR_W = 19,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned BURST   = 4
) (
    input  logic               CLK100MHZ,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [WADDR_W-1:0] addr0,
    input  logic [WADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0]  wdata0,
    input  logic [DATA_W-1:0]  wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [DATA_W-1:0]  rdata,
    output logic [RADDR_W-1:0] raddr_alu,
    output logic [WADDR_W-1:0] waddr_alu,
    output logic [DATA_W-1:0]  wdata_alu,
    output logic               wen_alu,
    input  logic [DATA_W-1:0]  rdata_alu
);

    localparam logic [3:0] BMAX = 4'(BURST);

    logic               ptr_q, ptr_d;
    logic               last_q, last_d;
    logic [3:0]         bcnt_q, bcnt_d;
    logic [3:0]         cnt_nx;
    logic               win;
    logic               gnt_any;
    logic               other;
    logic               sel_we;
    logic [WADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    logic               wen_q;
    logic [RADDR_W-1:0] raddr_q;
    logic [WADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [RD_LAT:0]    tv_q;
    logic [RD_LAT:0]    to_q;

    // Arbitration state: priority pointer, last owner, burst count
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            last_q <= 1'b0;
            bcnt_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= last_d;
            bcnt_q <= bcnt_d;
        end
    end

    // Next arbitration state; pointer follows the winner unless the burst expires
    always_comb begin
        ptr_d  = ptr_q;
        last_d = last_q;
        bcnt_d = bcnt_q;
        cnt_nx = 4'd1;
        other  = win ? req0 : req1;
        if (gnt_any) begin
            if (win == last_q && bcnt_q != '0) begin
                cnt_nx = (bcnt_q >= BMAX) ? BMAX : bcnt_q + 4'd1;
            end
            last_d = win;
            if (cnt_nx == BMAX && other) begin
                ptr_d  = ~win;
                bcnt_d = '0;
            end else begin
                ptr_d  = win;
                bcnt_d = cnt_nx;
            end
        end
    end

    // Winner select, grant strobes and selected request fields
    always_comb begin
        unique case (1'b1)
            (req0 & ~req1): win = 1'b0;
            (req1 & ~req0): win = 1'b1;
            default:        win = ptr_q;
        endcase
        gnt_any   = (req0 | req1) & rst_n;
        gnt0      = gnt_any & ~win;
        gnt1      = gnt_any & win;
        sel_we    = win ? we1 : we0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
    end

    // Registered memory-side port; addresses and data hold while idle
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= gnt_any & sel_we;
            if (gnt_any && !sel_we) begin
                raddr_q <= sel_addr[RADDR_W-1:0];
            end
            if (gnt_any && sel_we) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Read tag pipe; tail lines up with rdata_alu from the memory
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            tv_q <= '0;
            to_q <= '0;
        end else begin
            tv_q <= {tv_q[RD_LAT-1:0], gnt_any & ~sel_we};
            to_q <= {to_q[RD_LAT-1:0], win};
        end
    end

    // Output drive and read return routing
    always_comb begin
        raddr_alu = raddr_q;
        waddr_alu = waddr_q;
        wdata_alu = wdata_q;
        wen_alu   = wen_q;
        rdata     = rdata_alu;
        rvalid0   = tv_q[RD_LAT] & ~to_q[RD_LAT];
        rvalid1   = tv_q[RD_LAT] & to_q[RD_LAT];
    end

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Scoreboard bench for alu_port_arbiter: directed traffic,
// expected port ops and read data queued, checked by a monitor.
module tb_alu_port_arbiter;
  localparam int RD_LAT = 2;

  typedef struct {
    bit          src;
    bit          we;
    logic [18:0] addr;
    logic [11:0] data;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [18:0] addr0 = '0, addr1 = '0;
  logic [11:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, wen_alu;
  logic [11:0] rdata, wdata_alu, rdata_alu;
  logic [12:0] raddr_alu;
  logic [18:0] waddr_alu;
  logic [11:0] mpipe [RD_LAT];

  int compared = 0;
  int failed = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int gfirst = -1;
  int glast = -1;

  op_t d0 [$];
  op_t d1 [$];
  op_t xport [$];
  logic [11:0] rq0 [$];
  logic [11:0] rq1 [$];
  int lat0 [$];
  int lat1 [$];

  alu_port_arbiter #(
    .RADDR_W(13), .WADDR_W(19), .DATA_W(12),
    .RD_LAT(RD_LAT), .BURST(4)
  ) dut (
    .CLK100MHZ(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .raddr_alu(raddr_alu), .waddr_alu(waddr_alu),
    .wdata_alu(wdata_alu), .wen_alu(wen_alu),
    .rdata_alu(rdata_alu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // memory model: fixed content addr ^ 5B5, RD_LAT cycles late
  always @(posedge clk) begin
    mpipe[0] <= raddr_alu[11:0] ^ 12'h5B5;
    for (int i = 1; i < RD_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign rdata_alu = mpipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // driver: present queue heads, retire on an observed grant
  initial begin
    bit g0s, g1s;
    forever begin
      @(negedge clk);
      g0s = gnt0;
      g1s = gnt1;
      @(posedge clk);
      #1;
      if (g0s && d0.size() > 0) void'(d0.pop_front());
      if (g1s && d1.size() > 0) void'(d1.pop_front());
      req0 = d0.size() > 0;
      req1 = d1.size() > 0;
      if (req0) begin
        we0 = d0[0].we; addr0 = d0[0].addr; wdata0 = d0[0].data;
      end
      if (req1) begin
        we1 = d1[0].we; addr1 = d1[0].addr; wdata1 = d1[0].data;
      end
    end
  end

  // monitor: grant order, memory port contents, read return
  initial begin
    bit  pend = 0;
    op_t cur;
    op_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        lat0.delete();
        lat1.delete();
      end else begin
        if (pend) begin
          chk("port_wen", wen_alu, cur.we);
          if (cur.we) begin
            chk("port_waddr", waddr_alu, cur.addr);
            chk("port_wdata", wdata_alu, cur.data);
          end else begin
            chk("port_raddr", raddr_alu, cur.addr[12:0]);
          end
        end else if (wen_alu) begin
          chk("idle_wen", wen_alu, 0);
        end
        pend = 0;
        if (gnt0 && gnt1) chk("dual_grant", 1, 0);
        if (gnt0 || gnt1) begin
          glast = cyc;
          if (gfirst < 0) gfirst = cyc;
          if (xport.size() == 0) begin
            chk("grant_unexpected", 1, 0);
          end else begin
            e = xport.pop_front();
            chk("grant_src", gnt1, e.src);
            cur = e;
            pend = 1;
            if (!e.we) begin
              if (e.src) lat1.push_back(cyc + 1 + RD_LAT);
              else lat0.push_back(cyc + 1 + RD_LAT);
            end
          end
        end
      end
      if (rvalid0 && rvalid1) chk("dual_rvalid", 1, 0);
      if (rvalid0) begin
        rv_cnt++;
        if (rq0.size() == 0) chk("rvalid0_spurious", 1, 0);
        else chk("rdata0", rdata, rq0.pop_front());
        if (lat0.size() > 0) chk("rlat0", cyc, lat0.pop_front());
      end
      if (rvalid1) begin
        rv_cnt++;
        if (rq1.size() == 0) chk("rvalid1_spurious", 1, 0);
        else chk("rdata1", rdata, rq1.pop_front());
        if (lat1.size() > 0) chk("rlat1", cyc, lat1.pop_front());
      end
    end
  end

  function automatic op_t mk(input bit s, input bit w,
                             input logic [18:0] a,
                             input logic [11:0] d);
    op_t o;
    o.src = s; o.we = w; o.addr = a; o.data = d;
    return o;
  endfunction

  task automatic wait_drv(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #2;
      if (d0.size() == 0 && d1.size() == 0) break;
    end
    chk("drv_drain", d0.size() + d1.size(), 0);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #2;
      if (d0.size() + d1.size() + xport.size() == 0) break;
    end
    chk("idle_drain", d0.size() + d1.size() + xport.size(), 0);
    repeat (RD_LAT + 5) @(posedge clk);
  endtask

  initial begin
    int rv;
    // reset with both requesters pending
    d0.push_back(mk(0, 1, 19'h12345, 12'hABC));
    d1.push_back(mk(1, 1, 19'h00777, 12'h123));
    xport.push_back(mk(0, 1, 19'h12345, 12'hABC));
    xport.push_back(mk(1, 1, 19'h00777, 12'h123));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0", req0, 1);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_wen", wen_alu, 0);
    chk("rst_raddr", raddr_alu, 0);
    chk("rst_waddr", waddr_alu, 0);
    chk("rst_wdata", wdata_alu, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    @(posedge clk); #3;
    rst_n = 1;
    @(negedge clk);
    chk("first_gnt0", gnt0, 1);
    wait_idle(20);

    // single read from requester 1, upper address bits dropped
    d1.push_back(mk(1, 0, 19'h70010, 12'h000));
    xport.push_back(mk(1, 0, 19'h70010, 12'h000));
    rq1.push_back(12'h5A5);
    wait_idle(20);

    // fresh pointer, both requesters saturating the port
    @(posedge clk); #3; rst_n = 0;
    repeat (2) @(posedge clk);
    #3; rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      d0.push_back(mk(0, 1, 19'h00100 + 19'(i), 12'hA00 + 12'(i)));
      d1.push_back(mk(1, 1, 19'h00200 + 19'(i), 12'hB00 + 12'(i)));
    end
    for (int i = 0; i < 4; i++)
      xport.push_back(mk(0, 1, 19'h00100 + 19'(i), 12'hA00 + 12'(i)));
    for (int i = 0; i < 4; i++)
      xport.push_back(mk(1, 1, 19'h00200 + 19'(i), 12'hB00 + 12'(i)));
    for (int i = 4; i < 6; i++)
      xport.push_back(mk(0, 1, 19'h00100 + 19'(i), 12'hA00 + 12'(i)));
    for (int i = 4; i < 6; i++)
      xport.push_back(mk(1, 1, 19'h00200 + 19'(i), 12'hB00 + 12'(i)));
    gfirst = -1;
    wait_idle(40);
    chk("burst_span", glast - gfirst, 11);

    // paired reads from both requesters, overlapping in flight
    xport.push_back(mk(1, 0, 19'h00030, 12'h0));
    xport.push_back(mk(0, 0, 19'h00020, 12'h0));
    xport.push_back(mk(0, 0, 19'h00021, 12'h0));
    xport.push_back(mk(1, 0, 19'h00031, 12'h0));
    xport.push_back(mk(1, 0, 19'h00032, 12'h0));
    xport.push_back(mk(0, 0, 19'h00022, 12'h0));
    rq0.push_back(12'h595); rq0.push_back(12'h594); rq0.push_back(12'h597);
    rq1.push_back(12'h585); rq1.push_back(12'h584); rq1.push_back(12'h587);
    for (int k = 0; k < 3; k++) begin
      d0.push_back(mk(0, 0, 19'h00020 + 19'(k), 12'h0));
      d1.push_back(mk(1, 0, 19'h00030 + 19'(k), 12'h0));
      wait_drv(20);
    end
    wait_idle(20);
    chk("rq0_left", rq0.size(), 0);
    chk("rq1_left", rq1.size(), 0);

    // reset right after a read is accepted discards it
    rv = rv_cnt;
    d0.push_back(mk(0, 0, 19'h00040, 12'h0));
    xport.push_back(mk(0, 0, 19'h00040, 12'h0));
    wait_drv(20);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3; rst_n = 1;
    repeat (10) @(posedge clk);
    chk("reset_no_rvalid", rv_cnt - rv, 0);
    chk("xport_left", xport.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d compared", compared);
    $fatal(1, "watchdog");
  end
endmodule
